ntr_cmd_responder: RTL and testbench

//  Consumes the 8-byte NTR command word and its level-high ready flag from the parallel bus decoder.

---
 rtl/ntr_cmd_responder_pkg.sv | 29 ++
 rtl/ntr_cmd_responder_if.sv | 26 ++
 rtl/ntr_edge_detect.sv | 25 ++
 rtl/ntr_cmd_responder.sv | 123 ++++++++++++
 tb/tb_ntr_cmd_responder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ntr_cmd_responder_pkg.sv
// Shared definitions for the NTR command responder and later NTR stages.
//   - opcode constants for the 8-byte NTR command word (byte 0)
//   - default chip ID and dummy-read length
//   - responder state encoding
//   - helper that picks one byte of the chip ID
package ntr_cmd_responder_pkg;

  localparam logic [7:0] OP_LED   = 8'hFF;
  localparam logic [7:0] OP_ACT   = 8'h3C;
  localparam logic [7:0] OP_ID    = 8'h90;
  localparam logic [7:0] OP_DUMMY = 8'h9F;

  localparam logic [31:0] CHIP_ID_DEFAULT   = 32'h00000FC2;
  localparam logic [15:0] DUMMY_LEN_DEFAULT = 16'h2000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RESP_ID,
    ST_RESP_DUMMY,
    ST_DONE
  } state_t;

  // Chip ID is sent least-significant byte first.
  function automatic logic [7:0] id_byte(input logic [31:0] id, input logic [1:0] sel);
    return id[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ntr_cmd_responder_if.sv
// Bus bundle between the parallel command decoder / NTR pins and the responder.
//   cmd        64  assembled command word, byte k = cmd[8k+7:8k]
//   cmd_ready   1  level-high while cmd is valid
//   ntr_clk_s   1  debounced NTR bus clock (clk domain)
//   ntr_cs1_s   1  debounced CS1, active low (clk domain)
//   data_out    8  response byte toward the bus tristate
//   data_oe     1  drive enable for data_out
// master = decoder/pin side, slave = responder.
interface ntr_cmd_responder_if;
  logic [63:0] cmd;
  logic        cmd_ready;
  logic        ntr_clk_s;
  logic        ntr_cs1_s;
  logic [7:0]  data_out;
  logic        data_oe;

  modport master (
    output cmd, cmd_ready, ntr_clk_s, ntr_cs1_s,
    input  data_out, data_oe
  );

  modport slave (
    input  cmd, cmd_ready, ntr_clk_s, ntr_cs1_s,
    output data_out, data_oe
  );
endinterface

// File: rtl/ntr_edge_detect.sv
// Rising-edge detector for a signal already synchronous to clk.
//   clk, rst_n  clock, asynchronous active-low reset
//   sig         input level
//   rise        one-cycle pulse when sig is 1 and was 0 on the previous clk
// RST_VAL presets the history register; 1 suppresses a false edge on reset release.
module ntr_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev;

  // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RST_VAL;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/ntr_cmd_responder.sv
// NTR command responder.
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus          slave side of ntr_cmd_responder_if (command in, response byte out)
//   led          LED state, written by OP_LED from cmd[56]
//   activated    sticky, set by OP_ACT
//   busy         high whenever the responder is not idle
//   err_unknown  sticky, set by an unrecognised opcode
//   err_overrun  sticky, set by a new command while not idle (that command is dropped)
// OP_ID streams CHIP_ID bytes LSB first until deselected; OP_DUMMY streams
// DUMMY_LEN bytes of 0xFF. One byte advance per NTR clock rise.
module ntr_cmd_responder
  import ntr_cmd_responder_pkg::*;
#(
  parameter logic [31:0] CHIP_ID   = CHIP_ID_DEFAULT,
  parameter logic [15:0] DUMMY_LEN = DUMMY_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ntr_cmd_responder_if.slave   bus,
  output logic                 led,
  output logic                 activated,
  output logic                 busy,
  output logic                 err_unknown,
  output logic                 err_overrun
);

  state_t      state, state_next;
  logic [15:0] idx, idx_next;
  logic [7:0]  op;
  logic        led_bit;
  logic        ready_rise, clk_rise, cs1_rise;

  ntr_edge_detect #(.RST_VAL(1'b1)) u_ready_edge (
    .clk(clk), .rst_n(rst_n), .sig(bus.cmd_ready), .rise(ready_rise)
  );
  ntr_edge_detect #(.RST_VAL(1'b1)) u_clk_edge (
    .clk(clk), .rst_n(rst_n), .sig(bus.ntr_clk_s), .rise(clk_rise)
  );
  ntr_edge_detect #(.RST_VAL(1'b1)) u_cs1_edge (
    .clk(clk), .rst_n(rst_n), .sig(bus.ntr_cs1_s), .rise(cs1_rise)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_IDLE: if (ready_rise) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_ID: begin
            idx_next   = '0;
            state_next = ST_RESP_ID;
          end
          OP_DUMMY: begin
            idx_next   = '0;
            state_next = ST_RESP_DUMMY;
          end
          default: state_next = ST_DONE;
        endcase
      end
      // Deselect beats a simultaneous NTR clock rise: idx is left alone.
      ST_RESP_ID: begin
        if (cs1_rise)      state_next = ST_DONE;
        else if (clk_rise) idx_next = idx + 16'd1;
      end
      ST_RESP_DUMMY: begin
        if (cs1_rise) state_next = ST_DONE;
        else if (clk_rise) begin
          idx_next = idx + 16'd1;
          if (idx_next == DUMMY_LEN) state_next = ST_DONE;
        end
      end
      ST_DONE: if (!bus.cmd_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      op           <= '0;
      led_bit      <= 1'b0;
      led          <= 1'b0;
      activated    <= 1'b0;
      err_unknown  <= 1'b0;
      err_overrun  <= 1'b0;
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;

      if (ready_rise) begin
        if (state == ST_IDLE) begin
          op      <= bus.cmd[7:0];
          led_bit <= bus.cmd[56];
        end else begin
          err_overrun <= 1'b1;
        end
      end

      if (state == ST_DECODE) begin
        case (op)
          OP_LED:          led         <= led_bit;
          OP_ACT:          activated   <= 1'b1;
          OP_ID, OP_DUMMY: ;
          default:         err_unknown <= 1'b1;
        endcase
      end

      // Outputs are registered from the next state so byte 0 appears in the
      // first RESP cycle and each new byte one clk after its NTR clock rise.
      bus.data_oe <= (state_next == ST_RESP_ID) || (state_next == ST_RESP_DUMMY);
      if (state_next == ST_RESP_ID)         bus.data_out <= id_byte(CHIP_ID, idx_next[1:0]);
      else if (state_next == ST_RESP_DUMMY) bus.data_out <= 8'hFF;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ntr_cmd_responder.sv
// Self-checking bench for ntr_cmd_responder: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a behavioural model.
module tb_ntr_cmd_responder;
  import ntr_cmd_responder_pkg::*;

  localparam logic [31:0] CHIP_ID   = 32'h00000FC2;
  localparam logic [15:0] DUMMY_LEN = 16'd3;

  localparam int PH_IDLE   = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_STREAM = 2;
  localparam int PH_FINISH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led, activated, busy, err_unknown, err_overrun;

  ntr_cmd_responder_if bus ();

  ntr_cmd_responder #(.CHIP_ID(CHIP_ID), .DUMMY_LEN(DUMMY_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .led(led), .activated(activated), .busy(busy),
    .err_unknown(err_unknown), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         m_phase, m_count;
  bit         m_is_id;
  logic [7:0] m_op, m_out;
  logic       m_bit, m_led, m_act, m_eu, m_eo, m_oe;
  logic       p_ready, p_clk, p_cs1;

  task automatic model_reset();
    m_phase = PH_IDLE; m_count = 0; m_is_id = 1'b0;
    m_op = '0; m_out = '0; m_bit = 1'b0;
    m_led = 1'b0; m_act = 1'b0; m_eu = 1'b0; m_eo = 1'b0; m_oe = 1'b0;
    p_ready = 1'b1; p_clk = 1'b1; p_cs1 = 1'b1;
  endtask

  // Predicts outputs after the next clk rise from the inputs currently driven.
  task automatic model_step();
    bit r_ready, r_clk, r_cs1;
    r_ready = bus.cmd_ready & ~p_ready;
    r_clk   = bus.ntr_clk_s & ~p_clk;
    r_cs1   = bus.ntr_cs1_s & ~p_cs1;
    p_ready = bus.cmd_ready; p_clk = bus.ntr_clk_s; p_cs1 = bus.ntr_cs1_s;

    if (r_ready && m_phase != PH_IDLE) m_eo = 1'b1;
    case (m_phase)
      PH_IDLE: if (r_ready) begin
        m_op = bus.cmd[7:0]; m_bit = bus.cmd[56]; m_phase = PH_DECODE;
      end
      PH_DECODE: begin
        m_phase = PH_FINISH;
        if (m_op == 8'hFF) m_led = m_bit;
        else if (m_op == 8'h3C) m_act = 1'b1;
        else if (m_op == 8'h90 || m_op == 8'h9F) begin
          m_is_id = (m_op == 8'h90); m_count = 0; m_phase = PH_STREAM;
        end else m_eu = 1'b1;
      end
      PH_STREAM: begin
        if (r_cs1) m_phase = PH_FINISH;
        else if (r_clk) begin
          m_count++;
          if (!m_is_id && m_count == int'(DUMMY_LEN)) m_phase = PH_FINISH;
        end
      end
      default: if (!bus.cmd_ready) m_phase = PH_IDLE;
    endcase
    m_oe = (m_phase == PH_STREAM);
    if (m_oe) m_out = m_is_id ? 8'(CHIP_ID >> (8 * (m_count % 4))) : 8'hFF;
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cyc_data_oe", bus.data_oe, m_oe);
      check("cyc_data_out", bus.data_out, m_out);
      check("cyc_led", led, m_led);
      check("cyc_activated", activated, m_act);
      check("cyc_busy", busy, m_phase != PH_IDLE);
      check("cyc_err_unknown", err_unknown, m_eu);
      check("cyc_err_overrun", err_overrun, m_eo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic b);
    bus.cmd       = {$urandom, $urandom};
    bus.cmd[7:0]  = op;
    bus.cmd[56]   = b;
    bus.cmd_ready = 1'b1;
    step();
  endtask

  task automatic settle(input int n);
    bus.cmd_ready = 1'b0;
    bus.ntr_clk_s = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [7:0] exp_id [7];

  initial begin
    bus.cmd = '0; bus.cmd_ready = 1'b0; bus.ntr_clk_s = 1'b0; bus.ntr_cs1_s = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_data_oe", bus.data_oe, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_led", led, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    settle(2);

    // 1: LED on, then off
    issue(OP_LED, 1'b1); step();
    check("t1_led_on", led, 1);
    check("t1_no_oe", bus.data_oe, 0);
    settle(3);
    issue(OP_LED, 1'b0); step();
    check("t1_led_off", led, 0);
    settle(3);

    // 2: chip ID stream, then deselect
    bus.ntr_cs1_s = 1'b0; step();
    exp_id = '{8'hC2, 8'h0F, 8'h00, 8'h00, 8'hC2, 8'h0F, 8'h00};
    issue(OP_ID, 1'b0); step();
    check("t2_oe", bus.data_oe, 1);
    check("t2_byte0", bus.data_out, exp_id[0]);
    for (int i = 1; i < 7; i++) begin
      bus.ntr_clk_s = 1'b1; step();
      check($sformatf("t2_byte%0d", i), bus.data_out, exp_id[i]);
      check($sformatf("t2_oe%0d", i), bus.data_oe, 1);
      bus.ntr_clk_s = 1'b0; step();
    end
    bus.ntr_cs1_s = 1'b1; step();
    check("t2_oe_off", bus.data_oe, 0);
    settle(3);

    // 3: dummy read of DUMMY_LEN=3 bytes, ends without deselect
    bus.ntr_cs1_s = 1'b0; step();
    issue(OP_DUMMY, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_oe%0d", i), bus.data_oe, 1);
      check($sformatf("t3_byte%0d", i), bus.data_out, 8'hFF);
      bus.ntr_clk_s = 1'b1; step();
      bus.ntr_clk_s = 1'b0;
      if (i < 2) step();
    end
    check("t3_oe_off", bus.data_oe, 0);
    check("t3_hold", bus.data_out, 8'hFF);
    settle(3);

    // 4: overrun during stream, then simultaneous clock rise and deselect
    issue(OP_ID, 1'b0); step();
    bus.ntr_clk_s = 1'b1; step();
    bus.ntr_clk_s = 1'b0; step();
    bus.cmd_ready = 1'b0; step(); step();
    issue(OP_LED, 1'b1);
    check("t4_overrun", err_overrun, 1);
    check("t4_oe_kept", bus.data_oe, 1);
    check("t4_byte_kept", bus.data_out, 8'h0F);
    bus.ntr_clk_s = 1'b1; step();
    check("t4_next_byte", bus.data_out, 8'h00);
    bus.ntr_clk_s = 1'b0; step();
    bus.ntr_clk_s = 1'b1; bus.ntr_cs1_s = 1'b1; step();
    check("t4_cs1_wins_oe", bus.data_oe, 0);
    check("t4_cs1_wins_hold", bus.data_out, 8'h00);
    check("t4_led_untouched", led, 0);
    settle(3);

    // 5: unknown opcode, then reset in the middle of a dummy stream
    issue(8'h55, 1'b0); step();
    check("t5_err_unknown", err_unknown, 1);
    check("t5_no_oe", bus.data_oe, 0);
    settle(3);
    bus.ntr_cs1_s = 1'b0; step();
    issue(OP_DUMMY, 1'b0); step();
    check("t5_dummy_oe", bus.data_oe, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_oe", bus.data_oe, 0);
    check("t5_rst_out", bus.data_out, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_eu", err_unknown, 0);
    check("t5_rst_eo", err_overrun, 0);
    check("t5_rst_act", activated, 0);
    model_reset();
    bus.ntr_clk_s = 1'b1; bus.cmd_ready = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(); step();
    check("t5_release_busy", busy, 0);
    check("t5_release_oe", bus.data_oe, 0);

    // activation opcode
    issue(OP_ACT, 1'b0); step();
    check("t6_activated", activated, 1);
    settle(3);

    // randomized traffic
    begin
      int hold;
      logic [7:0] ops [6];
      ops = '{8'hFF, 8'h3C, 8'h90, 8'h9F, 8'h55, 8'h00};
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
        if (hold > 0) hold--;
        else if (bus.cmd_ready) begin
          bus.cmd_ready = 1'b0;
          hold = $urandom_range(1, 4);
        end else begin
          bus.cmd = {$urandom, $urandom};
          if ($urandom_range(0, 5) != 5) bus.cmd[7:0] = ops[$urandom_range(0, 4)];
          bus.cmd_ready = 1'b1;
          hold = $urandom_range(1, 30);
        end
        if ($urandom_range(0, 1) == 1) bus.ntr_clk_s = ~bus.ntr_clk_s;
        if (bus.ntr_cs1_s) begin
          if ($urandom_range(0, 3) == 0) bus.ntr_cs1_s = 1'b0;
        end else if ($urandom_range(0, 19) == 0) bus.ntr_cs1_s = 1'b1;
        step();
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
